// File: rtl/vga_checker_pkg.sv
// vga_checker_pkg: shared state encoding and CRC-16-CCITT constants for the VGA stream checker.
package vga_checker_pkg;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARM   = 3'd1;
  localparam logic [2:0] SYNC  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_SEED = 16'hFFFF;
endpackage

// File: rtl/vga_checker_crc16.sv
// vga_checker_crc16: CRC-16-CCITT register advancing 24 message bits (MSB first) per enabled cycle.
// Ports: clk, rst_n (async active-low); init loads the seed; en folds data[23:0] into crc.
module vga_checker_crc16
  import vga_checker_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [23:0] data,
  output logic [15:0] crc
);
  logic [15:0] nxt;
  always_comb begin
    nxt = crc;
    for (int i = 23; i >= 0; i--)
      nxt = {nxt[14:0], 1'b0} ^ ((nxt[15] ^ data[i]) ? CRC_POLY : 16'h0000);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc <= '0;
    else if (init) crc <= CRC_SEED;
    else if (en) crc <= nxt;
  end
endmodule

// File: rtl/vga_stream_checker.sv
// vga_stream_checker: on-chip checker comparing one VGA frame's pixel stream against a reference stream.
// Ports: Clock_50/Resetn (async active-low); Start/Avg_mode arm a check; VGA_Vsync, Pixel_strobe,
// Pixel_X/Y, DUT_R/G/B tap the VGA unit; Ref_valid/Ref_R/G/B/Ref_ready form the reference handshake;
// Busy, Done, Pass, Mismatch_count, Ref_underflow, First_err_X/Y/chan and Frame_crc report results.
// Define VGA_CHECKER_CRC_EN to build the frame CRC; otherwise Frame_crc is tied to zero.
module vga_stream_checker
  import vga_checker_pkg::*;
#(
  parameter int COLOR_W     = 10,
  parameter int REF_W       = 8,
  parameter int COORD_W     = 10,
  parameter int AREA_LEFT   = 160,
  parameter int AREA_RIGHT  = 480,
  parameter int AREA_TOP    = 120,
  parameter int AREA_BOTTOM = 360
) (
  input  logic               Clock_50,
  input  logic               Resetn,
  input  logic               Start,
  input  logic               Avg_mode,
  input  logic               VGA_Vsync,
  input  logic               Pixel_strobe,
  input  logic [COORD_W-1:0] Pixel_X,
  input  logic [COORD_W-1:0] Pixel_Y,
  input  logic [COLOR_W-1:0] DUT_R,
  input  logic [COLOR_W-1:0] DUT_G,
  input  logic [COLOR_W-1:0] DUT_B,
  input  logic               Ref_valid,
  input  logic [REF_W-1:0]   Ref_R,
  input  logic [REF_W-1:0]   Ref_G,
  input  logic [REF_W-1:0]   Ref_B,
  output logic               Ref_ready,
  output logic               Busy,
  output logic               Done,
  output logic               Pass,
  output logic [15:0]        Mismatch_count,
  output logic               Ref_underflow,
  output logic [COORD_W-1:0] First_err_X,
  output logic [COORD_W-1:0] First_err_Y,
  output logic [2:0]         First_err_chan,
  output logic [15:0]        Frame_crc
);
  localparam int PAD = COLOR_W - REF_W;
  localparam logic [COORD_W-1:0] X_LO = COORD_W'(AREA_LEFT);
  localparam logic [COORD_W-1:0] X_HI = COORD_W'(AREA_RIGHT);
  localparam logic [COORD_W-1:0] Y_LO = COORD_W'(AREA_TOP);
  localparam logic [COORD_W-1:0] Y_HI = COORD_W'(AREA_BOTTOM);

  logic [2:0] state;
  logic vsync_q, avg_q, seen, in_win, start_ok, use_avg, fail;
  logic [2:0] chan;
  logic [COLOR_W-1:0] ref_r, ref_g, ref_b, exp_r, exp_g, exp_b, prev_r, prev_g, prev_b;

  function automatic logic [COLOR_W-1:0] widen(input logic [REF_W-1:0] v);
    return COLOR_W'(v) << PAD;
  endfunction

  // Truncating mean of the previous and current expanded reference, with a carry bit.
  function automatic logic [COLOR_W-1:0] blend(input logic avg, input logic [COLOR_W-1:0] p,
                                               input logic [COLOR_W-1:0] c);
    logic [COLOR_W:0] s;
    s = {1'b0, p} + {1'b0, c};
    return avg ? s[COLOR_W:1] : c;
  endfunction

  assign start_ok = Start && (state == IDLE || state == DONE);
  assign in_win = Pixel_strobe && state == CHECK && Pixel_X >= X_LO && Pixel_X < X_HI &&
                  Pixel_Y >= Y_LO && Pixel_Y < Y_HI;
  assign ref_r = widen(Ref_R);
  assign ref_g = widen(Ref_G);
  assign ref_b = widen(Ref_B);
  // The leftmost column has no same-row predecessor, so it always compares directly.
  assign use_avg = avg_q && Pixel_X != X_LO;
  assign exp_r = blend(use_avg, prev_r, ref_r);
  assign exp_g = blend(use_avg, prev_g, ref_g);
  assign exp_b = blend(use_avg, prev_b, ref_b);
  assign chan = {exp_r != DUT_R, exp_g != DUT_G, exp_b != DUT_B};
  assign fail = !Ref_valid || |chan;
  assign Ref_ready = in_win;
  assign Busy = state == ARM || state == SYNC || state == CHECK;
  assign Done = state == DONE;
  assign Pass = Done && Mismatch_count == 16'h0000 && !Ref_underflow;

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state          <= IDLE;
      vsync_q        <= 1'b1;
      avg_q          <= 1'b0;
      seen           <= 1'b0;
      prev_r         <= '0;
      prev_g         <= '0;
      prev_b         <= '0;
      Mismatch_count <= '0;
      Ref_underflow  <= 1'b0;
      First_err_X    <= '0;
      First_err_Y    <= '0;
      First_err_chan <= '0;
    end else begin
      vsync_q <= VGA_Vsync;
      state <= start_ok ? ARM
             : (state == ARM && !vsync_q) ? SYNC
             : (state == SYNC && vsync_q) ? CHECK
             : (state == CHECK && !vsync_q) ? DONE : state;
      if (start_ok) begin
        avg_q          <= Avg_mode;
        seen           <= 1'b0;
        Mismatch_count <= '0;
        Ref_underflow  <= 1'b0;
        First_err_X    <= '0;
        First_err_Y    <= '0;
        First_err_chan <= '0;
      end else if (in_win) begin
        if (Ref_valid) begin
          prev_r <= ref_r;
          prev_g <= ref_g;
          prev_b <= ref_b;
        end
        if (fail) begin
          if (Mismatch_count != 16'hFFFF) Mismatch_count <= Mismatch_count + 16'd1;
          if (!Ref_valid) Ref_underflow <= 1'b1;
          if (!seen) begin
            seen           <= 1'b1;
            First_err_X    <= Pixel_X;
            First_err_Y    <= Pixel_Y;
            // An underflow pixel was never compared, so it reports no channel flags.
            First_err_chan <= Ref_valid ? chan : 3'b000;
          end
        end
      end
    end
  end

`ifdef VGA_CHECKER_CRC_EN
  vga_checker_crc16 u_crc (
    .clk  (Clock_50),
    .rst_n(Resetn),
    .init (start_ok),
    .en   (in_win),
    .data ({DUT_R[COLOR_W-1 -: 8], DUT_G[COLOR_W-1 -: 8], DUT_B[COLOR_W-1 -: 8]}),
    .crc  (Frame_crc)
  );
`else
  assign Frame_crc = 16'h0000;
`endif
endmodule

// File: tb/tb_vga_stream_checker.sv
// tb_vga_stream_checker: directed frames with randomized pixels checked against a behavioural frame model.
module tb_vga_stream_checker;
  localparam int L = 160, R = 208, T = 120, B = 136;
  localparam int XS = 156, XE = 212, YS = 118, YE = 138;

  logic Clock_50 = 1'b0, Resetn = 1'b1, Start = 1'b0, Avg_mode = 1'b0, VGA_Vsync = 1'b1;
  logic Pixel_strobe = 1'b0, Ref_valid = 1'b0;
  logic [9:0] Pixel_X = '0, Pixel_Y = '0, DUT_R = '0, DUT_G = '0, DUT_B = '0;
  logic [7:0] Ref_R = '0, Ref_G = '0, Ref_B = '0;
  logic Ref_ready, Busy, Done, Pass, Ref_underflow;
  logic [15:0] Mismatch_count, Frame_crc;
  logic [9:0] First_err_X, First_err_Y;
  logic [2:0] First_err_chan;

  int vectors = 0, miscompares = 0, rdy_cnt = 0, rdy_base = 0;
  int f_avg, ex, ey, ec, ux, uy, rnd, pin, cff, busy_at, stop_at;
  int m_cnt, m_fx, m_fy, m_fc, m_fcok, m_under, m_seen;
  logic [15:0] m_crc;

  vga_stream_checker #(
    .COLOR_W(10), .REF_W(8), .COORD_W(10),
    .AREA_LEFT(L), .AREA_RIGHT(R), .AREA_TOP(T), .AREA_BOTTOM(B)
  ) dut (
    .Clock_50(Clock_50), .Resetn(Resetn), .Start(Start), .Avg_mode(Avg_mode),
    .VGA_Vsync(VGA_Vsync), .Pixel_strobe(Pixel_strobe), .Pixel_X(Pixel_X), .Pixel_Y(Pixel_Y),
    .DUT_R(DUT_R), .DUT_G(DUT_G), .DUT_B(DUT_B), .Ref_valid(Ref_valid),
    .Ref_R(Ref_R), .Ref_G(Ref_G), .Ref_B(Ref_B), .Ref_ready(Ref_ready), .Busy(Busy),
    .Done(Done), .Pass(Pass), .Mismatch_count(Mismatch_count), .Ref_underflow(Ref_underflow),
    .First_err_X(First_err_X), .First_err_Y(First_err_Y), .First_err_chan(First_err_chan),
    .Frame_crc(Frame_crc)
  );

  always #10 Clock_50 = ~Clock_50;
  always @(posedge Clock_50) if (Ref_ready) rdy_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic defaults();
    f_avg = 0; ex = -1; ey = -1; ec = 1; ux = -1; uy = -1;
    rnd = 0; pin = 0; cff = 0; busy_at = -10; stop_at = -1;
  endtask

  task automatic run_frame();
    int idx, k, prev[3], er[3], e[3];
    logic [9:0] d[3];
    logic [7:0] rf[3];
    logic [2:0] ch;
    bit rv, inw;
    m_cnt = 0; m_under = 0; m_seen = 0; m_fx = 0; m_fy = 0; m_fc = 0; m_fcok = 1;
    m_crc = 16'hFFFF; idx = 0;
    for (int c = 0; c < 3; c++) prev[c] = 0;
    @(negedge Clock_50); Start = 1'b1; Avg_mode = f_avg[0];
    @(negedge Clock_50); Start = 1'b0;
    VGA_Vsync = 1'b0; repeat (4) @(negedge Clock_50);
    VGA_Vsync = 1'b1; repeat (4) @(negedge Clock_50);
    rdy_base = rdy_cnt;
    for (int y = YS; y < YE; y++)
      for (int x = XS; x < XE; x++) begin
        @(negedge Clock_50);
        if (idx == stop_at) return;
        if (idx == busy_at + 1) chk("busy_hold", {31'b0, Busy}, 1);
        Start = (idx == busy_at);
        Avg_mode = (idx == busy_at) ? !f_avg[0] : f_avg[0];
        inw = x >= L && x < R && y >= T && y < B;
        rv = inw ? !(x == ux && y == uy) : bit'($urandom_range(0, 1));
        for (int c = 0; c < 3; c++) rf[c] = cff != 0 ? 8'hFF : 8'($urandom);
        if (pin != 0 && y == T && x == L) for (int c = 0; c < 3; c++) rf[c] = 8'h10;
        if (pin != 0 && y == T && x == L + 1) for (int c = 0; c < 3; c++) rf[c] = 8'h11;
        for (int c = 0; c < 3; c++) begin
          er[c] = int'(rf[c]) * 4;
          e[c] = (f_avg != 0 && x != L) ? (prev[c] + er[c]) / 2 : er[c];
          d[c] = 10'(e[c]);
        end
        if (pin != 0 && y == T && x == L) for (int c = 0; c < 3; c++) d[c] = 10'h040;
        if (pin != 0 && y == T && x == L + 1) for (int c = 0; c < 3; c++) d[c] = 10'h042;
        if (x == ex && y == ey) d[ec] = d[ec] ^ 10'h020;
        if (rnd != 0 && $urandom_range(0, 99) < 3) begin
          k = int'($urandom_range(0, 2));
          d[k] = d[k] ^ 10'(1 << $urandom_range(0, 9));
        end
        if (!inw || !rv) for (int c = 0; c < 3; c++) d[c] = 10'($urandom);
        if (inw) begin
          if (rv) for (int c = 0; c < 3; c++) prev[c] = er[c];
          ch = {int'(d[0]) != e[0], int'(d[1]) != e[1], int'(d[2]) != e[2]};
          if (!rv || ch != 3'b000) begin
            m_cnt++;
            if (!rv) m_under = 1;
            if (m_seen == 0) begin
              m_seen = 1; m_fx = x; m_fy = y; m_fc = int'(ch); m_fcok = int'(rv);
            end
          end
          m_crc = crc_byte(crc_byte(crc_byte(m_crc, d[0][9:2]), d[1][9:2]), d[2][9:2]);
        end
        Pixel_strobe = 1'b1; Pixel_X = 10'(x); Pixel_Y = 10'(y);
        DUT_R = d[0]; DUT_G = d[1]; DUT_B = d[2];
        Ref_R = rf[0]; Ref_G = rf[1]; Ref_B = rf[2]; Ref_valid = rv;
        idx++;
      end
    @(negedge Clock_50); Pixel_strobe = 1'b0; Ref_valid = 1'b0; Start = 1'b0;
    repeat (3) @(negedge Clock_50);
    VGA_Vsync = 1'b0;
    for (int n = 0; n < 40 && !Done; n++) @(negedge Clock_50);
  endtask

  task automatic results();
    chk("done", {31'b0, Done}, 1);
    chk("busy_end", {31'b0, Busy}, 0);
    chk("pass", {31'b0, Pass}, (m_cnt == 0 && m_under == 0) ? 1 : 0);
    chk("mismatch_count", {16'b0, Mismatch_count}, m_cnt);
    chk("underflow", {31'b0, Ref_underflow}, m_under);
    chk("first_x", {22'b0, First_err_X}, m_fx);
    chk("first_y", {22'b0, First_err_Y}, m_fy);
    if (m_fcok != 0) chk("first_chan", {29'b0, First_err_chan}, m_fc);
    chk("ref_ready_pulses", rdy_cnt - rdy_base, (R - L) * (B - T));
`ifdef VGA_CHECKER_CRC_EN
    chk("frame_crc", {16'b0, Frame_crc}, {16'b0, m_crc});
`else
    chk("frame_crc_off", {16'b0, Frame_crc}, 0);
`endif
    VGA_Vsync = 1'b1;
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_busy"}, {31'b0, Busy}, 0);
    chk({tag, "_done"}, {31'b0, Done}, 0);
    chk({tag, "_pass"}, {31'b0, Pass}, 0);
    chk({tag, "_count"}, {16'b0, Mismatch_count}, 0);
    chk({tag, "_under"}, {31'b0, Ref_underflow}, 0);
    chk({tag, "_fx"}, {22'b0, First_err_X}, 0);
    chk({tag, "_fy"}, {22'b0, First_err_Y}, 0);
    chk({tag, "_fchan"}, {29'b0, First_err_chan}, 0);
    chk({tag, "_crc"}, {16'b0, Frame_crc}, 0);
    chk({tag, "_ready"}, {31'b0, Ref_ready}, 0);
  endtask

  initial begin
    #5 Resetn = 1'b0;
    repeat (3) @(negedge Clock_50);
    idle_outputs("reset");
    Resetn = 1'b1;

    defaults(); run_frame(); results();

    defaults(); ex = 200; ey = 130; ec = 1; run_frame(); results();
    chk("g_err_x", {22'b0, First_err_X}, 200);
    chk("g_err_y", {22'b0, First_err_Y}, 130);
    chk("g_err_chan", {29'b0, First_err_chan}, 3'b010);

    defaults(); f_avg = 1; pin = 1; run_frame(); results();

    defaults(); f_avg = 1; rnd = 1; run_frame(); results();

    defaults(); ux = 170; uy = 125; busy_at = 300; run_frame(); results();
    chk("uf_count", {16'b0, Mismatch_count}, 1);
    chk("uf_flag", {31'b0, Ref_underflow}, 1);

    defaults(); rnd = 1; stop_at = 600; run_frame();
    chk("pre_reset_busy", {31'b0, Busy}, 1);
    chk("pre_reset_count", {16'b0, Mismatch_count}, m_cnt);
    Resetn = 1'b0;
    #1 idle_outputs("midreset");
    @(negedge Clock_50); Resetn = 1'b1; Pixel_strobe = 1'b0; Ref_valid = 1'b0;
    defaults(); run_frame(); results();

    defaults(); cff = 1; run_frame(); results();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
